relu_layer_sched: RTL and testbench

- Per-layer controller for the directional-ReLU datapath. It sits between the bias stage and the output writer.
- Latches one layer configuration: relu enable plus four per-tuple fractional-length shifts. Holds that configuration stable on the ReLU control pins for the whole layer.
- Sequences a programmed number of bias vectors through the combinational ReLU.
- Registers each ReLU result into a 1-deep valid/ready output stage. Pulses done when the last result is consumed.

---
 rtl/relu_layer_sched.sv | 149 ++++++++++++++
 tb/tb_relu_layer_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_layer_sched.sv
// Per-layer controller for the directional-ReLU datapath: latches one
// layer config, streams cfg_num bias vectors through ReLU into a
// 1-deep valid/ready output register, and pulses layer_done at the end.
// Ports: cfg_* (layer config handshake), in_* (bias vector handshake),
// relu/relu_shift_ch* (ReLU control), relu_res (ReLU result),
// out_* (registered result stream), busy, layer_done.
module relu_layer_sched #(
  parameter int BW_FL       = 4,
  parameter int OUT_CHANNEL = 4,
  parameter int BW_RELU     = 34,
  parameter int BW_CNT      = 16
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic                           cfg_relu,
  input  logic [4*BW_FL-1:0]             cfg_shift,
  input  logic [BW_CNT-1:0]              cfg_num,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           relu,
  output logic [BW_FL-1:0]               relu_shift_ch0,
  output logic [BW_FL-1:0]               relu_shift_ch1,
  output logic [BW_FL-1:0]               relu_shift_ch2,
  output logic [BW_FL-1:0]               relu_shift_ch3,
  input  logic [OUT_CHANNEL*BW_RELU-1:0] relu_res,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_CHANNEL*BW_RELU-1:0] out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           layer_done
);

  localparam int DW = OUT_CHANNEL * BW_RELU;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                relu_q, relu_d;
  logic [4*BW_FL-1:0]  shift_q, shift_d;
  logic [BW_CNT-1:0]   total_q, total_d;
  logic [BW_CNT-1:0]   in_cnt_q, in_cnt_d;
  logic [BW_CNT-1:0]   out_cnt_q, out_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic                acc;
  logic                cons;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      total_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      total_q     <= total_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    total_d     = total_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // The output slot is free if empty or draining this cycle.
    in_ready = (state_q == RUN)
             && (in_cnt_q < total_q)
             && (!out_valid_q || out_ready);
    acc  = in_valid && in_ready;
    cons = out_valid_q && out_ready;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          relu_d    = cfg_relu;
          shift_d   = cfg_shift;
          total_d   = cfg_num;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (cfg_num == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (acc) begin
          out_data_d  = relu_res;
          out_valid_d = 1'b1;
          out_last_d  = (in_cnt_q == total_q - BW_CNT'(1));
          in_cnt_d    = in_cnt_q + BW_CNT'(1);
        end else if (cons) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (cons) begin
          out_cnt_d = out_cnt_q + BW_CNT'(1);
          // No accept can coincide: all inputs were already taken.
          if (out_last_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cfg_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign layer_done     = (state_q == DONE);
  assign relu           = relu_q;
  assign relu_shift_ch0 = shift_q[4*BW_FL-1 -: BW_FL];
  assign relu_shift_ch1 = shift_q[3*BW_FL-1 -: BW_FL];
  assign relu_shift_ch2 = shift_q[2*BW_FL-1 -: BW_FL];
  assign relu_shift_ch3 = shift_q[BW_FL-1 -: BW_FL];
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;

endmodule

// File: tb/tb_relu_layer_sched.sv
// Randomized scoreboard bench for relu_layer_sched.
// A layer-level model predicts handshakes; a monitor checks outputs.
module tb_relu_layer_sched;

  localparam int DW = 136;

  logic          clk = 1'b0;
  logic          srst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_relu;
  logic [15:0]   cfg_shift;
  logic [15:0]   cfg_num;
  logic          in_valid;
  logic          in_ready;
  logic          relu;
  logic [3:0]    sh0, sh1, sh2, sh3;
  logic [DW-1:0] relu_res;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          layer_done;

  relu_layer_sched dut (
    .clk            (clk),
    .srst           (srst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_relu       (cfg_relu),
    .cfg_shift      (cfg_shift),
    .cfg_num        (cfg_num),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .relu           (relu),
    .relu_shift_ch0 (sh0),
    .relu_shift_ch1 (sh1),
    .relu_shift_ch2 (sh2),
    .relu_shift_ch3 (sh3),
    .relu_res       (relu_res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .layer_done     (layer_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Phase of the layer: 0 idle, 1 streaming, 2 done pulse.
  int          m_state;
  logic        m_relu;
  logic [15:0] m_shift;
  int          m_total;
  int          m_acc;
  int          m_cons;
  logic        m_pend;
  int          n_done;

  logic [DW:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: every consumed result must match the queue head.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!srst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none",
                 out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[DW:1]);
        chk("out_last", DW'(out_last), DW'(e[0]));
      end
    end
  end

  // One clock: check control outputs against the model, advance it.
  task automatic tick();
    logic m_ir;
    logic acc;
    logic cons;
    @(negedge clk);
    if (srst) begin
      m_state = 0;
      m_relu  = 1'b0;
      m_shift = '0;
      m_total = 0;
      m_acc   = 0;
      m_cons  = 0;
      m_pend  = 1'b0;
      exp_q.delete();
    end else begin
      m_ir = (m_state == 1) && (m_acc < m_total)
          && (!m_pend || out_ready);
      chk("cfg_ready", DW'(cfg_ready), DW'(m_state == 0));
      chk("busy", DW'(busy), DW'(m_state != 0));
      chk("layer_done", DW'(layer_done), DW'(m_state == 2));
      chk("out_valid", DW'(out_valid), DW'(m_pend));
      chk("in_ready", DW'(in_ready), DW'(m_ir));
      chk("relu", DW'(relu), DW'(m_relu));
      chk("shift", DW'({sh0, sh1, sh2, sh3}), DW'(m_shift));
      if (m_state == 2) n_done++;
      acc  = in_valid && m_ir;
      cons = m_pend && out_ready;
      case (m_state)
        0: if (cfg_valid) begin
          m_relu  = cfg_relu;
          m_shift = cfg_shift;
          m_total = int'(cfg_num);
          m_acc   = 0;
          m_cons  = 0;
          m_state = (cfg_num == 0) ? 2 : 1;
        end
        1: begin
          if (cons) m_cons++;
          if (acc) begin
            exp_q.push_back({relu_res, m_acc == m_total - 1});
            m_acc++;
          end
          m_pend = acc || (m_pend && !cons);
          if (cons && m_cons == m_total) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_res();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    relu_res = t[DW-1:0];
  endtask

  task automatic run_layer(input logic r, input logic [15:0] sh,
                           input logic [15:0] num, input int pv,
                           input int pr, input int stall_at,
                           input int rst_at);
    int cyc;
    int stall;
    cyc   = 0;
    stall = 4;
    cfg_relu  = r;
    cfg_shift = sh;
    cfg_num   = num;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    while (m_state != 0 && cyc < 3000) begin
      if (rst_at >= 0 && m_acc == rst_at) begin
        srst     = 1'b1;
        in_valid = 1'b0;
        tick();
        srst = 1'b0;
      end else begin
        in_valid  = ($urandom_range(99) < pv);
        out_ready = ($urandom_range(99) < pr);
        if (stall_at >= 0 && m_acc == stall_at && stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end
        rand_res();
        cfg_valid = (m_state == 1) && $urandom_range(1) == 1;
        cfg_relu  = 1'($urandom);
        cfg_shift = 16'($urandom);
        cfg_num   = 16'($urandom);
        tick();
      end
      cyc++;
    end
    if (m_state != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL layer_timeout: got state %0d expected idle",
               m_state);
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int d0;
    srst      = 1'b1;
    cfg_valid = 1'b0;
    cfg_relu  = 1'b0;
    cfg_shift = '0;
    cfg_num   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    relu_res  = '0;
    n_done    = 0;
    tick();
    tick();
    srst = 1'b0;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", DW'(out_last), '0);
    in_valid = 1'b1;
    rand_res();
    tick();
    tick();
    in_valid = 1'b0;

    run_layer(1'b1, 16'h1234, 16'd3, 100, 100, -1, -1);
    chk("done_cnt_a", DW'(n_done), DW'(1));

    run_layer(1'b0, 16'hA5C3, 16'd8, 100, 100, 3, -1);
    chk("done_cnt_b", DW'(n_done), DW'(2));

    run_layer(1'b1, 16'h0F0F, 16'd0, 100, 100, -1, -1);
    chk("done_cnt_c", DW'(n_done), DW'(3));

    run_layer(1'b1, 16'h7777, 16'd5, 100, 100, -1, 2);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_relu", DW'(relu), '0);
    chk("done_cnt_d", DW'(n_done), DW'(3));
    run_layer(1'b0, 16'h4321, 16'd1, 100, 100, -1, -1);
    chk("done_cnt_e", DW'(n_done), DW'(4));

    for (int i = 0; i < 12; i++) begin
      d0 = n_done;
      run_layer(1'($urandom), 16'($urandom),
                16'($urandom_range(20)),
                $urandom_range(30, 100), $urandom_range(30, 100),
                -1, -1);
      chk("done_cnt_rand", DW'(n_done), DW'(d0 + 1));
    end

    tick();
    chk("queue_empty", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
